// File: rtl/counter_sequencer.sv
// Programmable interval timer: sequences a WIDTH-bit up-counter through IDLE/RUN/HOLD/DONE.
// Optional step prescaler and its `prescale` port are enabled by defining PRESCALE_EN.
module counter_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic                  cfg_periodic,
    input  logic                  start,
    input  logic                  stop,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tick,
    output logic                  done
`ifdef PRESCALE_EN
    ,
    input  logic [PRESCALE_W-1:0] prescale
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]      CountOne = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PresOne  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [WIDTH-1:0]      r_count;
    logic                  r_tick;
    logic [WIDTH-1:0]      r_period;
    logic                  r_periodic;
    logic [PRESCALE_W-1:0] r_presc;

    state_t                w_stateNext;
    logic [WIDTH-1:0]      w_countNext;
    logic                  w_tickNext;
    logic [WIDTH-1:0]      w_periodNext;
    logic                  w_periodicNext;
    logic [PRESCALE_W-1:0] w_prescNext;
    logic [PRESCALE_W-1:0] w_prescaleSel;
    logic                  w_stepDue;
    logic                  w_wrap;

    // Without the prescaler the compare value is zero, so every RUN cycle is a step.
`ifdef PRESCALE_EN
    assign w_prescaleSel = prescale;
`else
    assign w_prescaleSel = '0;
`endif

    assign w_stepDue = (r_presc == w_prescaleSel);
    assign w_wrap    = (r_count == (r_period - CountOne));

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state == RUN) || (r_state == HOLD);
    assign done      = (r_state == DONE);
    assign count     = r_count;
    assign tick      = r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_period   <= '0;
            r_periodic <= 1'b0;
            r_presc    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_count    <= w_countNext;
            r_tick     <= w_tickNext;
            r_period   <= w_periodNext;
            r_periodic <= w_periodicNext;
            r_presc    <= w_prescNext;
        end
    end

    // stop is tested before start in every state so a simultaneous request pauses/aborts.
    always_comb begin
        w_stateNext    = r_state;
        w_countNext    = r_count;
        w_tickNext     = 1'b0;
        w_periodNext   = r_period;
        w_periodicNext = r_periodic;
        w_prescNext    = r_presc;

        if (cfg_valid && (r_state == IDLE)) begin
            w_periodNext   = cfg_period;
            w_periodicNext = cfg_periodic;
        end

        case (r_state)
            IDLE: begin
                if (!stop && start && (r_period != '0)) begin
                    w_stateNext = RUN;
                    w_countNext = '0;
                    w_prescNext = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    w_stateNext = HOLD;
                end else if (w_stepDue) begin
                    w_prescNext = '0;
                    if (w_wrap) begin
                        w_countNext = '0;
                        w_tickNext  = 1'b1;
                        if (!r_periodic) begin
                            w_stateNext = DONE;
                        end
                    end else begin
                        w_countNext = r_count + CountOne;
                    end
                end else begin
                    w_prescNext = r_presc + PresOne;
                end
            end
            HOLD: begin
                if (stop) begin
                    w_stateNext = IDLE;
                    w_countNext = '0;
                end else if (start) begin
                    w_stateNext = RUN;
                end
            end
            DONE: begin
                w_countNext = '0;
                if (stop) begin
                    w_stateNext = IDLE;
                end else if (start) begin
                    w_stateNext = RUN;
                    w_prescNext = '0;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_countNext = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer; define PRESCALE_EN to also exercise the prescaler.
module tb_counter_sequencer;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic       cfg_periodic;
    logic       start;
    logic       stop;
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;
`ifdef PRESCALE_EN
    logic [3:0] prescale;
`endif

    int checks;
    int errors;

    counter_sequencer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .count        (count),
        .busy         (busy),
        .tick         (tick),
        .done         (done)
`ifdef PRESCALE_EN
        ,
        .prescale     (prescale)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic nextCycle;
        @(negedge clk);
    endtask

    task automatic applyConfig(input logic [7:0] p, input logic per);
        cfg_valid    = 1'b1;
        cfg_period   = p;
        cfg_periodic = per;
        nextCycle();
        cfg_valid    = 1'b0;
    endtask

    task automatic pulseStart;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic pulseStop;
        stop = 1'b1;
        nextCycle();
        stop = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_init: count=%0d busy=%b tick=%b done=%b ready=%b expected 0 0 0 0 1", count, busy, tick, done, cfg_ready);
        end
        applyConfig(8'd5, 1'b1);
        pulseStart();
        nextCycle();
        nextCycle();
        checks++;
        if (busy !== 1'b1 || count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL reset_prerun: busy=%b count=%0d expected 1 2", busy, count);
        end
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_midrun: count=%0d busy=%b tick=%b done=%b ready=%b expected 0 0 0 0 1", count, busy, tick, done, cfg_ready);
        end
        pulseStart();
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_period_cleared: busy=%b ready=%b expected 0 1", busy, cfg_ready);
        end
    endtask

    task automatic test_oneshot;
        logic [7:0] expCount;
        applyConfig(8'd5, 1'b0);
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            expCount = 8'(i);
            checks++;
            if (count !== expCount || tick !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL oneshot_step%0d: count=%0d tick=%b busy=%b done=%b expected %0d 0 1 0", i, count, tick, busy, done, expCount);
            end
            nextCycle();
        end
        checks++;
        if (count !== 8'd0 || tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_wrap: count=%0d tick=%b done=%b busy=%b expected 0 1 1 0", count, tick, done, busy);
        end
        nextCycle();
        checks++;
        if (tick !== 1'b0 || done !== 1'b1 || count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL oneshot_after: tick=%b done=%b count=%0d expected 0 1 0", tick, done, count);
        end
        pulseStart();
        nextCycle();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL oneshot_restart: busy=%b done=%b count=%0d expected 1 0 1", busy, done, count);
        end
        pulseStop();
        pulseStop();
        checks++;
        if (cfg_ready !== 1'b1 || count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL oneshot_abort: ready=%b count=%0d expected 1 0", cfg_ready, count);
        end
    endtask

    task automatic test_periodic;
        int tickCount;
        int lastTick;
        logic [7:0] expCount;
        logic expTick;
        tickCount = 0;
        lastTick  = -1;
        applyConfig(8'd3, 1'b1);
        pulseStart();
        for (int i = 0; i < 13; i++) begin
            expCount = 8'(i % 3);
            expTick  = (i > 0) && (i % 3 == 0);
            checks++;
            if (count !== expCount || tick !== expTick || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL periodic_c%0d: count=%0d tick=%b done=%b expected %0d %b 0", i, count, tick, done, expCount, expTick);
            end
            if (tick === 1'b1) begin
                if (lastTick >= 0) begin
                    checks++;
                    if (i - lastTick != 3) begin
                        errors++;
                        $display("[TB] FAIL periodic_spacing: got %0d expected 3", i - lastTick);
                    end
                end
                lastTick = i;
                tickCount++;
            end
            nextCycle();
        end
        checks++;
        if (tickCount != 4) begin
            errors++;
            $display("[TB] FAIL periodic_ticks: got %0d expected 4", tickCount);
        end
        pulseStop();
        pulseStop();
    endtask

    task automatic test_pause_abort;
        applyConfig(8'd8, 1'b0);
        pulseStart();
        nextCycle();
        nextCycle();
        pulseStop();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (count !== 8'd2 || busy !== 1'b1 || tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pause_hold%0d: count=%0d busy=%b tick=%b expected 2 1 0", i, count, busy, tick);
            end
            nextCycle();
        end
        pulseStart();
        checks++;
        if (count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL pause_resume: count=%0d expected 2", count);
        end
        nextCycle();
        checks++;
        if (count !== 8'd3) begin
            errors++;
            $display("[TB] FAIL pause_step3: count=%0d expected 3", count);
        end
        nextCycle();
        checks++;
        if (count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL pause_step4: count=%0d expected 4", count);
        end
        pulseStop();
        checks++;
        if (count !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_hold: count=%0d busy=%b expected 4 1", count, busy);
        end
        pulseStop();
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_idle: count=%0d busy=%b ready=%b expected 0 0 1", count, busy, cfg_ready);
        end
    endtask

    task automatic test_edge_cases;
        logic [7:0] expCount;
        applyConfig(8'd8, 1'b0);
        pulseStart();
        nextCycle();
        pulseStop();
        start = 1'b1;
        stop  = 1'b1;
        nextCycle();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 8'd0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL edge_startstop_hold: busy=%b count=%0d ready=%b expected 0 0 1", busy, count, cfg_ready);
        end
        applyConfig(8'd0, 1'b1);
        pulseStart();
        nextCycle();
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || count !== 8'd0 || tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL edge_period0: busy=%b ready=%b count=%0d tick=%b expected 0 1 0 0", busy, cfg_ready, count, tick);
        end
        applyConfig(8'd4, 1'b1);
        pulseStart();
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL edge_ready_run: ready=%b expected 0", cfg_ready);
        end
        cfg_valid    = 1'b1;
        cfg_period   = 8'd2;
        cfg_periodic = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expCount = 8'(i % 4);
            checks++;
            if (count !== expCount || tick !== (i == 4) || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL edge_cfg_ignored%0d: count=%0d tick=%b busy=%b expected %0d %b 1", i, count, tick, busy, expCount, (i == 4));
            end
            nextCycle();
        end
        cfg_valid = 1'b0;
        pulseStop();
        pulseStop();
        applyConfig(8'd1, 1'b1);
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (count !== 8'd0 || tick !== (i > 0)) begin
                errors++;
                $display("[TB] FAIL edge_period1_%0d: count=%0d tick=%b expected 0 %b", i, count, tick, (i > 0));
            end
            nextCycle();
        end
        pulseStop();
        pulseStop();
    endtask

    task automatic test_max_period;
        logic [7:0] expCount;
        applyConfig(8'd255, 1'b0);
        pulseStart();
        for (int i = 0; i < 255; i++) begin
            expCount = 8'(i);
            if (i == 0 || i == 128 || i == 254) begin
                checks++;
                if (count !== expCount || tick !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL max_count%0d: count=%0d tick=%b expected %0d 0", i, count, tick, expCount);
                end
            end
            nextCycle();
        end
        checks++;
        if (count !== 8'd0 || tick !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_wrap: count=%0d tick=%b done=%b expected 0 1 1", count, tick, done);
        end
        pulseStop();
        checks++;
        if (cfg_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL max_done_stop: ready=%b done=%b expected 1 0", cfg_ready, done);
        end
    endtask

`ifdef PRESCALE_EN
    task automatic test_prescale;
        logic [7:0] expCount;
        prescale = 4'd2;
        applyConfig(8'd2, 1'b1);
        pulseStart();
        for (int i = 0; i < 13; i++) begin
            expCount = 8'((i / 3) % 2);
            checks++;
            if (count !== expCount || tick !== ((i > 0) && (i % 6 == 0))) begin
                errors++;
                $display("[TB] FAIL prescale_c%0d: count=%0d tick=%b expected %0d %b", i, count, tick, expCount, ((i > 0) && (i % 6 == 0)));
            end
            nextCycle();
        end
        pulseStop();
        pulseStop();
        prescale = 4'd0;
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        cfg_valid    = 1'b0;
        cfg_period   = 8'd0;
        cfg_periodic = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
`ifdef PRESCALE_EN
        prescale     = 4'd0;
`endif
        nextCycle();
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause_abort();
        test_edge_cases();
        test_max_period();
`ifdef PRESCALE_EN
        test_prescale();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
